// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-ported main memory. Every access runs
// IDLE -> SETUP -> ACCESS -> ACK so strobes never overlap address/data changes.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_adress,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_indata,
   input  logic [DATA_W-1:0] mem_outdata,
   output logic              busy,
   output logic              last_grant
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      ACK    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
   logic                last_grant_q, last_grant_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic                a_ack_q, a_ack_d;
   logic                b_ack_q, b_ack_d;
   logic                busy_q, busy_d;
   logic                grant_en_c;
   logic                grant_b_c;

   // B wins when alone, or when both ask and round-robin says A went last
   assign grant_en_c = (state_q == IDLE) && (a_req || b_req);
   assign grant_b_c  = b_req && (!a_req || ((FIXED_PRIO == 0) && !last_grant_q));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (a_req || b_req) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control outputs are decoded from the next state so they register cleanly
   always_comb begin
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      busy_d      = (state_d != IDLE);
      case (state_d)
         ACCESS: begin
            mem_write_d = we_q;
            mem_read_d  = !we_q;
         end
         ACK: begin
            a_ack_d = !owner_q;
            b_ack_d = owner_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      last_grant_d = last_grant_q;
      a_rdata_d    = a_rdata_q;
      b_rdata_d    = b_rdata_q;
      if (grant_en_c) begin
         owner_d      = grant_b_c;
         we_d         = grant_b_c ? b_we    : a_we;
         addr_d       = grant_b_c ? b_addr  : a_addr;
         wdata_d      = grant_b_c ? b_wdata : a_wdata;
         last_grant_d = grant_b_c;
      end
      if ((state_q == ACCESS) && !we_q) begin
         if (owner_q) b_rdata_d = mem_outdata;
         else         a_rdata_d = mem_outdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
         last_grant_q <= 1'b1;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         a_ack_q      <= 1'b0;
         b_ack_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
         last_grant_q <= last_grant_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         a_ack_q      <= a_ack_d;
         b_ack_q      <= b_ack_d;
         busy_q       <= busy_d;
      end
   end

   assign mem_adress = addr_q;
   assign mem_indata = wdata_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign a_ack      = a_ack_q;
   assign b_ack      = b_ack_q;
   assign a_rdata    = a_rdata_q;
   assign b_rdata    = b_rdata_q;
   assign busy       = busy_q;
   assign last_grant = last_grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, multi-cycle corner sequences and
// randomized transactions against a transaction-level memory/arbitration model.
module tb_mem_port_arbiter;

   logic        clk, reset_n, mem_init;
   logic        a_req, a_we, b_req, b_we;
   logic [11:0] a_addr, b_addr, mem_adress;
   logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_indata, mem_outdata;
   logic        a_ack, b_ack, mem_read, mem_write, busy, last_grant;

   logic        f_a_req, f_b_req, f_a_ack, f_b_ack, f_mem_read, f_mem_write, f_busy, f_last_grant;
   logic [11:0] f_mem_adress;
   logic [15:0] f_a_rdata, f_b_rdata, f_mem_indata, f_mem_outdata;

   logic [15:0] mem [4096];
   int          n_checks = 0;
   int          n_pass   = 0;

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .FIXED_PRIO(0)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_adress(mem_adress), .mem_read(mem_read), .mem_write(mem_write),
      .mem_indata(mem_indata), .mem_outdata(mem_outdata), .busy(busy), .last_grant(last_grant)
   );

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .FIXED_PRIO(1)) u_fp (
      .clk(clk), .reset_n(reset_n),
      .a_req(f_a_req), .a_we(1'b0), .a_addr(12'h0AA), .a_wdata(16'h0), .a_ack(f_a_ack), .a_rdata(f_a_rdata),
      .b_req(f_b_req), .b_we(1'b0), .b_addr(12'h0BB), .b_wdata(16'h0), .b_ack(f_b_ack), .b_rdata(f_b_rdata),
      .mem_adress(f_mem_adress), .mem_read(f_mem_read), .mem_write(f_mem_write),
      .mem_indata(f_mem_indata), .mem_outdata(f_mem_outdata), .busy(f_busy), .last_grant(f_last_grant)
   );

   assign mem_outdata   = mem[mem_adress];
   assign f_mem_outdata = {4'h0, f_mem_adress};

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
      end else if (mem_write) begin
         mem[mem_adress] <= mem_indata;
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic do_reset(input logic init_mem);
      @(negedge clk);
      reset_n  = 1'b0;
      mem_init = init_mem;
      @(negedge clk);
      reset_n  = 1'b1;
      mem_init = 1'b0;
   endtask

   // One transaction from an idle negedge; owner 0=A 1=B 2=timeout 3=both acked
   task automatic run_txn(input logic ar, input logic aw, input logic [11:0] aa, input logic [15:0] ad,
                          input logic br, input logic bw, input logic [11:0] ba, input logic [15:0] bd,
                          input logic chg, output int owner, output int lat, output int n_rd,
                          output int n_wr, output logic [11:0] st_addr, output int n_both);
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
      owner = 2; lat = 0; n_rd = 0; n_wr = 0; st_addr = '0; n_both = 0;
      for (int c = 1; c <= 12 && owner == 2; c++) begin
         @(negedge clk);
         if (c == 1 && chg) begin
            a_addr = aa ^ 12'h010; b_addr = ba ^ 12'h010; a_wdata = ~ad; b_wdata = ~bd;
         end
         if (mem_read)  begin n_rd++; st_addr = mem_adress; end
         if (mem_write) begin n_wr++; st_addr = mem_adress; end
         if (mem_read && mem_write) n_both++;
         if (a_ack || b_ack) begin
            owner = a_ack ? (b_ack ? 3 : 0) : 1;
            lat   = c;
            a_req = 1'b0; b_req = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic        ar, aw;
      logic [11:0] aa;
      logic [15:0] ad;
      logic        br, bw;
      logic [11:0] ba;
      logic [15:0] bd;
      int          exp_owner;
      logic [15:0] exp_ard, exp_brd;
   } vec_t;

   vec_t        vt[7];
   logic [15:0] ref_mem [4096];

   initial begin
      int          own, lat, nrd, nwr, nboth, k, cyc, ew_i, acks;
      logic [11:0] sadr, ea;
      logic        ew;
      logic        rar, rbr, raw, rbw, ref_last;
      logic [11:0] raa, rba, oa;
      logic [15:0] rad, rbd, ref_ard, ref_brd;
      int          ref_own;

      vt[0] = '{1'b1, 1'b1, 12'h005, 16'h1234, 1'b0, 1'b0, 12'h000, 16'h0000, 0, 16'h0000, 16'h0000};
      vt[1] = '{1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 0, 16'h1234, 16'h0000};
      vt[2] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'hFFF, 16'hBEEF, 1, 16'h1234, 16'h0000};
      vt[3] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 0, 16'hBEEF, 16'h0000};
      vt[4] = '{1'b1, 1'b0, 12'h007, 16'h0000, 1'b1, 1'b0, 12'h009, 16'h0000, 1, 16'hBEEF, 16'h0009};
      vt[5] = '{1'b1, 1'b0, 12'h007, 16'h0000, 1'b1, 1'b0, 12'h009, 16'h0000, 0, 16'h0007, 16'h0009};
      vt[6] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'hFFF, 16'h0000, 1, 16'h0007, 16'hBEEF};

      reset_n = 1'b0; mem_init = 1'b1;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      f_a_req = 1'b0; f_b_req = 1'b0;
      @(negedge clk);
      check("rst_ctrl", {27'b0, mem_read, mem_write, a_ack, b_ack, busy}, 32'h0);
      check("rst_mem_bus", {4'h0, mem_adress, mem_indata}, 32'h0);
      check("rst_rdata", {a_rdata, b_rdata}, 32'h0);
      check("rst_last_grant", 32'(last_grant), 32'h1);
      reset_n = 1'b1; mem_init = 1'b0;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 7; i++) begin
         run_txn(vt[i].ar, vt[i].aw, vt[i].aa, vt[i].ad, vt[i].br, vt[i].bw, vt[i].ba, vt[i].bd,
                 1'b0, own, lat, nrd, nwr, sadr, nboth);
         ew = (vt[i].exp_owner == 1) ? vt[i].bw : vt[i].aw;
         ea = (vt[i].exp_owner == 1) ? vt[i].ba : vt[i].aa;
         ew_i = ew ? 1 : 0;
         check("tbl_owner", own, vt[i].exp_owner);
         check("tbl_latency", lat, 3);
         check("tbl_wr_pulses", nwr, ew_i);
         check("tbl_rd_pulses", nrd, 1 - ew_i);
         check("tbl_strobe_addr", 32'(sadr), 32'(ea));
         check("tbl_overlap", nboth, 0);
         check("tbl_a_rdata", 32'(a_rdata), 32'(vt[i].exp_ard));
         check("tbl_b_rdata", 32'(b_rdata), 32'(vt[i].exp_brd));
         check("tbl_last_grant", 32'(last_grant), vt[i].exp_owner);
         check("tbl_idle_busy", 32'(busy), 32'h0);
      end

      // Round-robin with both requests held continuously
      do_reset(1'b0);
      a_req = 1'b1; a_we = 1'b0; a_addr = 12'h100;
      b_req = 1'b1; b_we = 1'b0; b_addr = 12'h101;
      k = 0;
      for (int c = 1; c <= 24 && k < 4; c++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            check("rr_owner", {31'b0, b_ack}, k % 2);
            check("rr_single_ack", 32'(a_ack & b_ack), 32'h0);
            check("rr_ack_cycle", c, 3 + 4 * k);
            check("rr_last_grant", 32'(last_grant), k % 2);
            k++;
            if (k == 4) begin a_req = 1'b0; b_req = 1'b0; end
         end
      end
      check("rr_ack_count", k, 4);
      @(negedge clk);
      check("rr_a_rdata", 32'(a_rdata), 32'h0100);
      check("rr_b_rdata", 32'(b_rdata), 32'h0101);

      // Fixed priority: A keeps winning until it drops its request
      f_a_req = 1'b1; f_b_req = 1'b1;
      k = 0; cyc = 0;
      for (int c = 1; c <= 40 && k < 4; c++) begin
         @(negedge clk);
         if (f_a_ack || f_b_ack) begin
            check("fp_owner", {31'b0, f_b_ack}, (k == 3) ? 1 : 0);
            check("fp_last_grant", 32'(f_last_grant), (k == 3) ? 1 : 0);
            if (k > 0 && k < 3) check("fp_ack_spacing", c - cyc, 4);
            cyc = c;
            k++;
            if (k == 3) f_a_req = 1'b0;
            if (k == 4) f_b_req = 1'b0;
         end
      end
      check("fp_ack_count", k, 4);
      @(negedge clk);

      // Reset asserted during the write strobe
      a_req = 1'b1; a_we = 1'b1; a_addr = 12'h010; a_wdata = 16'h5555;
      @(negedge clk);
      @(negedge clk);
      check("rstacc_strobe", 32'(mem_write), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("rstacc_write_drop", 32'(mem_write), 32'h0);
      check("rstacc_busy", 32'(busy), 32'h0);
      a_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      acks = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (a_ack || b_ack) acks++;
      end
      check("rstacc_no_ack", acks, 0);
      run_txn(1'b1, 1'b0, 12'h010, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, own, lat, nrd, nwr, sadr, nboth);
      check("rstacc_owner", own, 0);
      check("rstacc_readback", 32'(a_rdata), 32'h0010);

      // Requester inputs change during SETUP: latched values must be used
      run_txn(1'b1, 1'b0, 12'h020, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b1, own, lat, nrd, nwr, sadr, nboth);
      check("chg_strobe_addr", 32'(sadr), 32'h020);
      check("chg_rdata", 32'(a_rdata), 32'h0020);
      run_txn(1'b1, 1'b1, 12'h040, 16'hC0DE, 1'b0, 1'b0, 12'h0, 16'h0, 1'b1, own, lat, nrd, nwr, sadr, nboth);
      run_txn(1'b0, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 12'h040, 16'h0, 1'b0, own, lat, nrd, nwr, sadr, nboth);
      check("chg_write_data", 32'(b_rdata), 32'hC0DE);

      // Randomized transactions against the transaction-level model
      do_reset(1'b1);
      for (int i = 0; i < 4096; i++) ref_mem[i] = 16'(i);
      ref_last = 1'b1; ref_ard = '0; ref_brd = '0;
      for (int t = 0; t < 80; t++) begin
         rar = 1'($urandom_range(0, 1)); rbr = 1'($urandom_range(0, 1));
         if (!rar && !rbr) rar = 1'b1;
         raw = 1'($urandom_range(0, 1)); rbw = 1'($urandom_range(0, 1));
         raa = 12'($urandom_range(0, 7)); if (raa == 12'h7) raa = 12'hFFF;
         rba = 12'($urandom_range(0, 7)); if (rba == 12'h7) rba = 12'hFFF;
         rad = 16'($urandom); rbd = 16'($urandom);
         if (rar && rbr) ref_own = ref_last ? 0 : 1;
         else            ref_own = rbr ? 1 : 0;
         oa = (ref_own == 1) ? rba : raa;
         if ((ref_own == 1) ? rbw : raw) ref_mem[oa] = (ref_own == 1) ? rbd : rad;
         else if (ref_own == 1)          ref_brd = ref_mem[oa];
         else                            ref_ard = ref_mem[oa];
         ref_last = (ref_own == 1);
         run_txn(rar, raw, raa, rad, rbr, rbw, rba, rbd, 1'b0, own, lat, nrd, nwr, sadr, nboth);
         check("rnd_owner", own, ref_own);
         check("rnd_strobe_addr", 32'(sadr), 32'(oa));
         check("rnd_a_rdata", 32'(a_rdata), 32'(ref_ard));
         check("rnd_b_rdata", 32'(b_rdata), 32'(ref_brd));
         check("rnd_last_grant", 32'(last_grant), 32'(ref_last));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester controller for the 4096x16 main memory (adress/read/write/indata/outdata interface).
- Sequences every access as setup -> strobe -> acknowledge, so memory control lines are never asserted while address or data change.
- Shares the memory between port A (CPU fetch/execute) and port B (I/O / program loader).
- Arbitration is round-robin or fixed-priority.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 16, memory word width.
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins a simultaneous request.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A request; held high until a_ack is seen.
- a_we  input  1  port A: 1 = write, 0 = read.
- a_addr  input  ADDR_W  port A address.
- a_wdata  input  DATA_W  port A write data.
- a_ack  output  1  port A one-cycle completion pulse.
- a_rdata  output  DATA_W  port A read data register.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B.
- mem_adress  output  ADDR_W  to memory adress.
- mem_read  output  1  to memory read.
- mem_write  output  1  to memory write.
- mem_indata  output  DATA_W  to memory indata.
- mem_outdata  input  DATA_W  from memory outdata (combinational read).
- busy  output  1  high in any state other than IDLE.
- last_grant  output  1  0 = A was granted last; 1 = B was granted last.

Behaviour:
- States: IDLE, SETUP, ACCESS, ACK; 2-bit registered state.

IDLE:
- If any request is present at a rising edge, the arbiter selects an owner and goes to SETUP.
- At the same edge it latches owner, we, addr and wdata into internal registers.
- Later changes on the requester inputs are ignored until the next grant.

Arbitration:
- Only one requester: that requester wins.
- Both request, FIXED_PRIO=0: the port not equal to last_grant wins.
- Both request, FIXED_PRIO=1: A wins.
- last_grant updates at the grant edge.

SETUP:
- mem_adress and mem_indata are driven from the latched registers.
- mem_read = 0, mem_write = 0.
- Next state is ACCESS unconditionally.

ACCESS:
- Address and data are held.
- If latched we=1: mem_write = 1 for exactly this cycle.
- If latched we=0: mem_read = 1 for exactly this cycle, and mem_outdata is captured into the owner's rdata register at the closing edge.
- Next state is ACK.

ACK:
- The owner's ack is high for exactly this cycle; the other port's ack stays 0.
- rdata is already valid during ACK.
- Next state is IDLE.

Requester timing and throughput:
- The requester drops req at the edge where it samples ack=1.
- Latency is 3 cycles from the grant edge to the ack cycle.
- Throughput is one access per 4 cycles.
- A req still high in IDLE is a new request.

Output hold rules:
- a_rdata and b_rdata hold their value until that port's next read completes.
- Writes do not alter rdata.
- mem_adress and mem_indata hold their last values in IDLE and ACK.
- mem_read and mem_write are 0 outside ACCESS; both are never high together.

Reset (asynchronous, reset_n=0):
- Immediately: state = IDLE; mem_read, mem_write, a_ack, b_ack, busy = 0.
- mem_adress, mem_indata, a_rdata, b_rdata = 0.
- last_grant = 1, so A wins the first simultaneous request.
- Reset during ACCESS aborts the strobe the same instant; no ack is issued and the requester must re-request.
- Release is synchronised by normal edge sampling; first grant is possible at the first edge after release.

Address width:
- Addresses are passed through unmodified; 0xFFF is valid and there is no wrap logic.

Test Plan:
- A writes 0x1234 to 0x005, then reads 0x005 -> mem_write high exactly 1 cycle (ACCESS); a_ack 3 cycles after each grant; a_rdata = 0x1234; b_ack never high.
- a_req and b_req both held continuously, FIXED_PRIO=0, after reset -> grants alternate A, B, A, B; last_grant toggles 0, 1, 0, 1; each ack 4 cycles apart.
- Same stimulus with FIXED_PRIO=1 -> A granted every transaction while it keeps requesting; B granted only in an IDLE where a_req = 0.
- B writes 0xBEEF to 0xFFF, then A reads 0xFFF -> a_rdata = 0xBEEF; b_rdata unchanged (0 after reset).
- reset_n pulsed low mid-ACCESS of an A write to 0x010 (old content 0x0010) -> mem_write drops with reset_n; busy = 0; no a_ack; a later read of 0x010 returns 0x0010.
- A changes a_addr from 0x020 to 0x030 during SETUP -> memory access uses 0x020.
